// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
package pipeline_pkg;

  // Operand source selects for the E-stage ALU inputs.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Sequencing states of the controller.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } ctrl_state_t;

  // ResultSrcE encoding that marks a load in E.
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the datapath (master) and the hazard controller (slave).
interface pipeline_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]            ResultSrcE;
  logic                  RegWriteM, RegWriteW, PCSrcE, MemReqM, DMemReady;
  logic                  StallF, StallD, StallE, StallM;
  logic                  FlushD, FlushE, FlushW;
  logic [1:0]            ForwardAE, ForwardBE;
  logic                  MemTimeout;
  logic [CNT_W-1:0]      StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
    output RegWriteM, RegWriteW, PCSrcE, MemReqM, DMemReady,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemTimeout, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
    input  RegWriteM, RegWriteW, PCSrcE, MemReqM, DMemReady,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemTimeout, StallCount
  );
endinterface

// File: rtl/forward_unit.sv
// Operand forwarding select for one E-stage ALU source register.
module forward_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  output fwd_sel_t              fwd_sel
);

  // M holds the younger producer so it wins over W; x0 is never forwarded.
  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      fwd_sel = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: stage stall/flush enables, ALU forwarding,
// data-memory wait handling with timeout, saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  pipeline_ctrl_if.slave bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic mem_stall, lw_stall;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  logic [REG_ADDR_W-1:0] rs_e [2];
  fwd_sel_t              fwd_sel [2];

  assign rs_e[0] = bus.Rs1E;
  assign rs_e[1] = bus.Rs2E;

  // One forwarding unit per ALU operand (0 = A, 1 = B).
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
      .rs_e        (rs_e[gi]),
      .rd_m        (bus.RdM),
      .rd_w        (bus.RdW),
      .reg_write_m (bus.RegWriteM),
      .reg_write_w (bus.RegWriteW),
      .fwd_sel     (fwd_sel[gi])
    );
  end

  assign mem_stall = bus.MemReqM && !bus.DMemReady;
  assign lw_stall  = (bus.ResultSrcE == RESULT_SRC_MEM) && (bus.RdE != '0) &&
                     ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  // Stall/flush enables in priority order: error, memory wait, redirect, load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if ((state_q == ERROR) || mem_stall) begin
      // Freeze F..M and drain W; a taken branch in E is re-seen on release.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (bus.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Next state, wait counter and saturating stall counter.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        // A ready in the final wait cycle still releases to RUN.
        if (!mem_stall) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
    if ((stall_f || stall_d || stall_e || stall_m) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.StallF     = stall_f;
  assign bus.StallD     = stall_d;
  assign bus.StallE     = stall_e;
  assign bus.StallM     = stall_m;
  assign bus.FlushD     = flush_d;
  assign bus.FlushE     = flush_e;
  assign bus.FlushW     = flush_w;
  assign bus.ForwardAE  = fwd_sel[0];
  assign bus.ForwardBE  = fwd_sel[1];
  assign bus.MemTimeout = (state_q == ERROR);
  assign bus.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random traffic
// against a run-length based reference model.
module tb_pipeline_ctrl;

  localparam int RW      = 5;
  localparam int TMO     = 16;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  pipeline_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit in_error    = 0;
  int waited      = 0;   // consecutive memory-stall cycles seen so far
  int stall_total = 0;   // saturating stall-cycle tally

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fwd_model(input logic [RW-1:0] rs);
    if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return 2;
    if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return 1;
    return 0;
  endfunction

  task automatic set_idle();
    bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0;
    bus.RdE = '0; bus.RdM = '0; bus.RdW = '0; bus.ResultSrcE = 2'b00;
    bus.RegWriteM = 0; bus.RegWriteW = 0; bus.PCSrcE = 0;
    bus.MemReqM = 0; bus.DMemReady = 0;
  endtask

  // Compare all outputs mid-cycle, then advance the model across the next rising edge.
  task automatic cycle(input string tag);
    bit ms, lw, sf, sd, se, sm, fd, fe, fw;
    @(negedge clk);
    ms = bus.MemReqM && !bus.DMemReady;
    lw = (bus.ResultSrcE == 2'b01) && bus.RdE != 0 &&
         (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
    {sf, sd, se, sm, fd, fe, fw} = '0;
    if (in_error || ms) begin
      {sf, sd, se, sm, fw} = '1;
    end else if (bus.PCSrcE) begin
      {fd, fe} = '1;
    end else if (lw) begin
      {sf, sd, fe} = '1;
    end
    chk({tag, "_StallF"}, bus.StallF, sf);
    chk({tag, "_StallD"}, bus.StallD, sd);
    chk({tag, "_StallE"}, bus.StallE, se);
    chk({tag, "_StallM"}, bus.StallM, sm);
    chk({tag, "_FlushD"}, bus.FlushD, fd);
    chk({tag, "_FlushE"}, bus.FlushE, fe);
    chk({tag, "_FlushW"}, bus.FlushW, fw);
    chk({tag, "_FwdA"}, bus.ForwardAE, fwd_model(bus.Rs1E));
    chk({tag, "_FwdB"}, bus.ForwardBE, fwd_model(bus.Rs2E));
    chk({tag, "_MemTimeout"}, bus.MemTimeout, in_error);
    chk({tag, "_StallCount"}, bus.StallCount, stall_total);
    @(posedge clk);
    if ((sf || sd || se || sm) && stall_total < CNT_MAX) stall_total++;
    if (!in_error) begin
      if (ms) begin
        waited++;
        if (waited == TMO + 1) in_error = 1;
      end else begin
        waited = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    in_error = 0; waited = 0; stall_total = 0;
    chk({tag, "_async_MemTimeout"}, bus.MemTimeout, 0);
    chk({tag, "_async_StallCount"}, bus.StallCount, 0);
    @(posedge clk);
    #1;
    chk({tag, "_held_StallCount"}, bus.StallCount, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    set_idle();
    do_reset("rst0");
    cycle("idle");

    // 1. M priority over W, then W when M no longer matches.
    bus.RdM = 5; bus.RegWriteM = 1; bus.Rs1E = 5; bus.RdW = 5; bus.RegWriteW = 1;
    cycle("t1a");
    chk("t1_fwdA_M", bus.ForwardAE, 2'b10);
    bus.RdM = 0;
    cycle("t1b");
    chk("t1_fwdA_W", bus.ForwardAE, 2'b01);

    // 2. x0 is never forwarded.
    set_idle();
    bus.Rs2E = 0; bus.RdM = 0; bus.RegWriteM = 1;
    cycle("t2");
    chk("t2_fwdB_x0", bus.ForwardBE, 2'b00);

    // 3. Load-use: one bubble, counter +1.
    set_idle();
    base = stall_total;
    bus.ResultSrcE = 2'b01; bus.RdE = 7; bus.Rs2D = 7;
    cycle("t3a");
    chk("t3_StallF", bus.StallF, 1);
    chk("t3_FlushE", bus.FlushE, 1);
    bus.ResultSrcE = 2'b00; bus.RdE = 0;
    cycle("t3b");
    chk("t3_release", bus.StallD, 0);
    chk("t3_count", bus.StallCount, base + 1);

    // 4. Redirect beats a load-use hazard.
    bus.ResultSrcE = 2'b01; bus.RdE = 9; bus.Rs1D = 9; bus.PCSrcE = 1;
    cycle("t4");
    chk("t4_FlushD", bus.FlushD, 1);
    chk("t4_StallF", bus.StallF, 0);

    // 5. Three-cycle memory wait with a branch arriving during the wait.
    set_idle();
    base = stall_total;
    bus.MemReqM = 1;
    cycle("t5w0");
    bus.PCSrcE = 1;
    cycle("t5w1");
    chk("t5_noflushD", bus.FlushD, 0);
    cycle("t5w2");
    bus.DMemReady = 1; bus.PCSrcE = 0;
    cycle("t5rel");
    chk("t5_StallM", bus.StallM, 0);
    chk("t5_count", bus.StallCount, base + 3);

    // Random traffic with small register indices to provoke matches.
    for (int n = 0; n < 300; n++) begin
      bus.Rs1D = RW'($urandom_range(0, 3)); bus.Rs2D = RW'($urandom_range(0, 3));
      bus.Rs1E = RW'($urandom_range(0, 3)); bus.Rs2E = RW'($urandom_range(0, 3));
      bus.RdE  = RW'($urandom_range(0, 3)); bus.RdM  = RW'($urandom_range(0, 3));
      bus.RdW  = RW'($urandom_range(0, 3));
      bus.ResultSrcE = 2'($urandom_range(0, 3));
      bus.RegWriteM = 1'($urandom); bus.RegWriteW = 1'($urandom);
      bus.PCSrcE = ($urandom_range(0, 3) == 0);
      bus.MemReqM = ($urandom_range(0, 2) == 0);
      bus.DMemReady = 1'($urandom);
      cycle("rnd");
    end

    // Ready in the final wait cycle wins over the timeout.
    set_idle();
    do_reset("rst1");
    bus.MemReqM = 1;
    for (int n = 0; n < TMO; n++) cycle("late_wait");
    bus.DMemReady = 1;
    cycle("late_ready");
    chk("late_no_timeout", bus.MemTimeout, 0);

    // 6. Timeout, sticky error, counter saturation, reset out of ERROR.
    set_idle();
    do_reset("rst2");
    bus.MemReqM = 1;
    for (int n = 0; n < TMO + 1; n++) cycle("tmo_wait");
    chk("t6_MemTimeout", bus.MemTimeout, 1);
    bus.DMemReady = 1;
    for (int n = 0; n < CNT_MAX; n++) cycle("t6_err");
    chk("t6_stuck", bus.StallE, 1);
    chk("t6_saturated", bus.StallCount, CNT_MAX);
    do_reset("rst3");
    chk("t6_rst_MemTimeout", bus.MemTimeout, 0);
    cycle("t6_run");
    chk("t6_run_StallF", bus.StallF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
